reexe_stage: RTL

//  - Re-execute (REEXE) pipeline stage, directly downstream of the PREMEM second-branch-amend stage.
//  - Latches the amended up-pipe result, waits for the non-blocking mul/div result when marked, then hands off to writeback/commit.
//  - Drives forwarding data/mode for the up-pipe; drives REEXE allowin back to PREMEM.

---
 rtl/reexe_pkg.sv | 34 +++
 rtl/reexe_if.sv | 50 +++++
 rtl/reexe_nb_wait.sv | 49 ++++
 rtl/reexe_stage.sv | 92 +++++++++
 4 files changed

// File: rtl/reexe_pkg.sv
// Shared types for the re-execute stage: widths, forwarding modes, states.
// Optional REEXE_PERF_CNT_EN adds a WAIT_NB cycle counter in reexe_stage.
package reexe_pkg;

    localparam int DATA_W = 32;
    localparam int GPR_W  = 5;
    localparam int EXC_W  = 5;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_WAIT  = 2'd1,
        FWD_READY = 2'd2
    } fwd_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_WAIT_NB = 2'd1,
        ST_READY   = 2'd2
    } reexe_state_e;

    typedef struct packed {
        logic [GPR_W-1:0]  wnum;
        logic [DATA_W-1:0] vaddr;
        logic [DATA_W-1:0] data;
        logic              exc;
        logic [EXC_W-1:0]  code;
    } reexe_payload_t;

    // An excepting instruction never waits for the mul/div result.
    function automatic logic needs_nb_wait(logic non_block, logic has_exc);
        return non_block && !has_exc;
    endfunction

endpackage

// File: rtl/reexe_if.sv
// Handshake and payload bundle between PREMEM, REEXE and WB.
// slave = the REEXE stage, master = its environment.
interface reexe_if;
    import reexe_pkg::*;

    logic              in_valid_i;
    logic [GPR_W-1:0]  in_writeNum_i;
    logic [DATA_W-1:0] in_VAddr_i;
    logic [DATA_W-1:0] in_aluRes_i;
    logic              in_nonBlock_i;
    logic              in_hasExc_i;
    logic [EXC_W-1:0]  in_ExcCode_i;
    logic              excFlush_i;
    logic              nb_done_i;
    logic [DATA_W-1:0] nb_data_i;
    logic              next_allowin_i;
    logic              allowin_o;
    logic              out_valid_o;
    logic [GPR_W-1:0]  out_writeNum_o;
    logic [DATA_W-1:0] out_data_o;
    logic [DATA_W-1:0] out_VAddr_o;
    logic              out_hasExc_o;
    logic [EXC_W-1:0]  out_ExcCode_o;
    logic [GPR_W-1:0]  fwd_writeNum_o;
    logic [DATA_W-1:0] fwd_data_o;
    logic [1:0]        fwd_mode_o;
    logic              nb_cancel_o;
    logic [31:0]       perf_nbStall_o;

    modport slave (
        input  in_valid_i, in_writeNum_i, in_VAddr_i, in_aluRes_i,
        input  in_nonBlock_i, in_hasExc_i, in_ExcCode_i,
        input  excFlush_i, nb_done_i, nb_data_i, next_allowin_i,
        output allowin_o, out_valid_o, out_writeNum_o, out_data_o,
        output out_VAddr_o, out_hasExc_o, out_ExcCode_o,
        output fwd_writeNum_o, fwd_data_o, fwd_mode_o,
        output nb_cancel_o, perf_nbStall_o
    );

    modport master (
        output in_valid_i, in_writeNum_i, in_VAddr_i, in_aluRes_i,
        output in_nonBlock_i, in_hasExc_i, in_ExcCode_i,
        output excFlush_i, nb_done_i, nb_data_i, next_allowin_i,
        input  allowin_o, out_valid_o, out_writeNum_o, out_data_o,
        input  out_VAddr_o, out_hasExc_o, out_ExcCode_o,
        input  fwd_writeNum_o, fwd_data_o, fwd_mode_o,
        input  nb_cancel_o, perf_nbStall_o
    );

endinterface

// File: rtl/reexe_nb_wait.sv
// REEXE occupancy FSM: EMPTY / WAIT_NB / READY plus the cancel pulse
// that kills an in-flight mul/div when a flush hits WAIT_NB.
module reexe_nb_wait
    import reexe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_nonBlock,
    input  logic         in_hasExc,
    input  logic         flush,
    input  logic         nb_done,
    input  logic         next_allowin,
    output reexe_state_e state,
    output logic         allowin,
    output logic         capture,
    output logic         nb_load,
    output logic         nb_cancel
);

    // Held in reset, the stage refuses new work.
    assign allowin = rst && ((state == ST_EMPTY) ||
                             (state == ST_READY && next_allowin));

    // A flush wins over capture and over a same-cycle nb_done.
    assign capture = in_valid && allowin && !flush;
    assign nb_load = (state == ST_WAIT_NB) && nb_done && !flush;

    // State transitions and the registered one-cycle cancel pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            nb_cancel <= 1'b0;
        end else begin
            nb_cancel <= flush && (state == ST_WAIT_NB);
            if (flush) begin
                state <= ST_EMPTY;
            end else if (capture) begin
                state <= needs_nb_wait(in_nonBlock, in_hasExc) ?
                         ST_WAIT_NB : ST_READY;
            end else if (nb_load) begin
                state <= ST_READY;
            end else if (state == ST_READY && next_allowin) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: rtl/reexe_stage.sv
// Re-execute stage: holds the amended up-pipe result, merges the mul/div
// result, forwards it and hands it to WB. Option: REEXE_PERF_CNT_EN.
module reexe_stage
    import reexe_pkg::*;
(
    input logic   clk,
    input logic   rst,
    reexe_if.slave bus
);

    reexe_state_e   state;
    reexe_payload_t pl;
    logic           allowin;
    logic           capture;
    logic           nb_load;
    logic           nb_cancel;

    reexe_nb_wait u_nb_wait (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (bus.in_valid_i),
        .in_nonBlock  (bus.in_nonBlock_i),
        .in_hasExc    (bus.in_hasExc_i),
        .flush        (bus.excFlush_i),
        .nb_done      (bus.nb_done_i),
        .next_allowin (bus.next_allowin_i),
        .state        (state),
        .allowin      (allowin),
        .capture      (capture),
        .nb_load      (nb_load),
        .nb_cancel    (nb_cancel)
    );

    // Payload: load on capture, merge mul/div data, clear when emptied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pl <= '0;
        end else if (bus.excFlush_i) begin
            pl <= '0;
        end else if (capture) begin
            pl.wnum  <= bus.in_writeNum_i;
            pl.vaddr <= bus.in_VAddr_i;
            pl.data  <= bus.in_aluRes_i;
            pl.exc   <= bus.in_hasExc_i;
            pl.code  <= bus.in_ExcCode_i;
        end else if (nb_load) begin
            pl.data <= bus.nb_data_i;
        end else if (state == ST_READY && bus.next_allowin_i) begin
            pl <= '0;
        end
    end

    // Forwarding mode follows occupancy: stall consumers while waiting.
    always_comb begin
        bus.fwd_mode_o = FWD_NONE;
        unique case (state)
            ST_WAIT_NB: bus.fwd_mode_o = FWD_WAIT;
            ST_READY:   bus.fwd_mode_o = FWD_READY;
            default:    bus.fwd_mode_o = FWD_NONE;
        endcase
    end

    assign bus.allowin_o     = allowin;
    assign bus.out_valid_o   = (state == ST_READY) && !bus.excFlush_i;
    assign bus.out_writeNum_o = pl.exc ? '0 : pl.wnum;
    assign bus.out_data_o    = pl.data;
    assign bus.out_VAddr_o   = pl.vaddr;
    assign bus.out_hasExc_o  = pl.exc;
    assign bus.out_ExcCode_o = pl.code;
    assign bus.fwd_writeNum_o = (state != ST_EMPTY && !pl.exc) ?
                                pl.wnum : '0;
    assign bus.fwd_data_o    = pl.data;
    assign bus.nb_cancel_o   = nb_cancel;

`ifdef REEXE_PERF_CNT_EN
    logic [31:0] nb_stall_cnt;

    // Count every WAIT_NB cycle; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            nb_stall_cnt <= '0;
        end else if (state == ST_WAIT_NB) begin
            nb_stall_cnt <= nb_stall_cnt + 32'd1;
        end
    end

    assign bus.perf_nbStall_o = nb_stall_cnt;
`else
    assign bus.perf_nbStall_o = '0;
`endif

endmodule
